// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its PLL / meter-reset consumers.
// The slave modport is the sequencer side. The master modport is the driving environment.
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    modport slave (
        input  pll_lock,
        input  restart,
        output pll_reset,
        output sys_rst,
        output ready,
        output fault,
        output lock_lost,
        output retry_cnt
    );

    modport master (
        output pll_lock,
        output restart,
        input  pll_reset,
        input  sys_rst,
        input  ready,
        input  fault,
        input  lock_lost,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, and holds meter logic in reset until stable.
// Lock timeouts retry up to MAX_RETRY times, then the block latches a fault until restart.
//
// state       | meaning
// RST_PLL     | PLL reset pin held high for RST_PULSE_CYC cycles
// WAIT_LOCK   | PLL reset released, waiting for lock with a timeout
// STABLE      | lock seen, requiring STABLE_CYC uninterrupted cycles
// RUN         | lock qualified, meter logic released, ready high
// FAULT       | retries exhausted, PLL held in reset until restart
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int STABLE_CYC       = 1024,
    parameter int MAX_RETRY        = 3
) (
    input  logic clkin,
    input  logic reset,
    pll_lock_sequencer_if.slave bus
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CNT = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RST_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             sync1_q, sync2_q;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             lock_lost_q, lock_lost_d;
    logic             lock_s;

    // pll_lock comes straight off the PLL pin, unrelated to clkin
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.pll_lock;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= S_RST_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        if (bus.restart) begin
            state_d = S_RST_PLL;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_RST_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock arriving on the timeout cycle still wins
                    if (lock_s) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAULT;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = S_RST_PLL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        lock_lost_d = 1'b1;
                        retry_d     = '0;
                        state_d     = S_RST_PLL;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_RST_PLL;
                end
            endcase
        end

        // Counter restarts on every transition; restart also re-arms a pulse already in progress
        if (bus.restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == S_RST_PLL) || (state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        pll_reset_d = (state_d == S_RST_PLL) || (state_d == S_FAULT);
        sys_rst_d   = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus randomized lock/restart traffic against a behavioural model.
// The model tracks remaining pulse/timeout cycles and the consecutive-lock run rather than a counter.
module tb_pll_lock_sequencer;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int SC = 8;
    localparam int MR = 2;

    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_QUAL  = 2;
    localparam int M_RUN   = 3;
    localparam int M_DEAD  = 4;

    logic clkin = 1'b0;
    logic reset = 1'b1;

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .RST_PULSE_CYC   (RP),
        .LOCK_TIMEOUT_CYC(TO),
        .STABLE_CYC      (SC),
        .MAX_RETRY       (MR)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clkin = ~clkin;

    int vectors    = 0;
    int miscompares = 0;

    int mode;
    int pulse_left;
    int wait_left;
    int qual_run;
    int retries;
    bit lost;
    bit lock_hist[$];

    function void model_reset();
        mode       = M_PULSE;
        pulse_left = RP;
        wait_left  = TO;
        qual_run   = 0;
        retries    = 0;
        lost       = 1'b0;
        lock_hist  = '{1'b0, 1'b0};
    endfunction

    function void model_step(input bit lock_in, input bit rst_in);
        bit ls;
        ls = lock_hist.pop_front();
        lock_hist.push_back(lock_in);
        lost = 1'b0;
        if (rst_in) begin
            mode       = M_PULSE;
            pulse_left = RP;
            retries    = 0;
        end else begin
            case (mode)
                M_PULSE: begin
                    pulse_left--;
                    if (pulse_left == 0) begin
                        mode      = M_WAIT;
                        wait_left = TO;
                    end
                end
                M_WAIT: begin
                    if (ls) begin
                        mode     = M_QUAL;
                        qual_run = 0;
                    end else begin
                        wait_left--;
                        if (wait_left == 0) begin
                            if (retries == MR) begin
                                mode = M_DEAD;
                            end else begin
                                retries++;
                                mode       = M_PULSE;
                                pulse_left = RP;
                            end
                        end
                    end
                end
                M_QUAL: begin
                    if (!ls) begin
                        mode      = M_WAIT;
                        wait_left = TO;
                    end else begin
                        qual_run++;
                        if (qual_run == SC) mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (!ls) begin
                        lost       = 1'b1;
                        retries    = 0;
                        mode       = M_PULSE;
                        pulse_left = RP;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function logic [8:0] model_out();
        return {(mode == M_PULSE) || (mode == M_DEAD), mode != M_RUN, mode == M_RUN,
                mode == M_DEAD, lost, 4'(retries)};
    endfunction

    function logic [8:0] dut_out();
        return {bus.pll_reset, bus.sys_rst, bus.ready, bus.fault, bus.lock_lost, bus.retry_cnt};
    endfunction

    task check_vec(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive, clock once, then compare at the next falling edge
    task cycle(input bit lock_in, input bit rst_in, input string tag);
        bus.pll_lock = lock_in;
        bus.restart  = rst_in;
        @(posedge clkin);
        model_step(lock_in, rst_in);
        @(negedge clkin);
        bus.restart = 1'b0;
        check_vec(tag, dut_out(), model_out());
    endtask

    task rand_run(input int n);
        int seg;
        bit lv;
        bit rs;
        seg = 0;
        lv  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (seg == 0) begin
                lv  = ($urandom_range(0, 3) != 0);
                seg = $urandom_range(1, 30);
            end
            seg--;
            rs = ($urandom_range(0, 79) == 0);
            cycle(lv, rs, "random");
        end
    endtask

    initial begin
        int hi;
        int n;
        int lost_cnt;
        int rises;
        int seen_ready;
        logic prev_rst;
        logic [3:0] last_retry;
        int retry_seq[$];

        bus.pll_lock = 1'b0;
        bus.restart  = 1'b0;
        model_reset();
        repeat (3) @(negedge clkin);
        check_vec("reset_values", dut_out(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        reset = 1'b0;

        // 1. nominal sequence
        hi = int'(bus.pll_reset);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, "t1_pulse");
            if (bus.pll_reset) hi++;
            else break;
        end
        check_int("t1_pulse_len", hi, RP);
        repeat (3) cycle(1'b0, 1'b0, "t1_wait");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, "t1_lock");
            n++;
            if (bus.ready) break;
        end
        check_int("t1_ready_latency", n, 2 + 1 + SC);
        check_int("t1_sys_rst", int'(bus.sys_rst), 0);
        check_int("t1_retry", int'(bus.retry_cnt), 0);
        repeat (3) cycle(1'b1, 1'b0, "t1_run");

        // 4. lock loss in RUN
        lost_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, "t4_drop");
            lost_cnt += int'(bus.lock_lost);
            if (bus.pll_reset) break;
        end
        check_int("t4_ready_sysrst", int'({bus.ready, bus.sys_rst}), 1);
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, "t4_pulse");
            lost_cnt += int'(bus.lock_lost);
            if (bus.pll_reset) hi++;
            else break;
        end
        check_int("t4_pulse_len", hi, RP);
        check_int("t4_lost_pulses", lost_cnt, 1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, "t4_reseq");
            if (bus.ready) break;
        end
        check_int("t4_ready_again", int'(bus.ready), 1);

        // 3. lock glitch during qualification
        cycle(1'b0, 1'b1, "t3_restart");
        repeat (RP + 3) cycle(1'b0, 1'b0, "t3_wait");
        seen_ready = 0;
        repeat (5) begin
            cycle(1'b1, 1'b0, "t3_high");
            seen_ready += int'(bus.ready);
        end
        cycle(1'b0, 1'b0, "t3_glitch");
        seen_ready += int'(bus.ready);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, "t3_relock");
            n++;
            if (bus.ready) break;
        end
        check_int("t3_no_early_ready", seen_ready, 0);
        check_int("t3_ready_latency", n, 2 + 1 + SC);
        check_int("t3_retry", int'(bus.retry_cnt), 0);

        // 2. timeout with retry, ending in fault
        cycle(1'b0, 1'b1, "t2_restart");
        prev_rst   = bus.pll_reset;
        last_retry = bus.retry_cnt;
        rises = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b0, "t2_timeout");
            if (bus.pll_reset && !prev_rst) rises++;
            prev_rst = bus.pll_reset;
            if (bus.retry_cnt != last_retry) retry_seq.push_back(int'(bus.retry_cnt));
            last_retry = bus.retry_cnt;
            if (bus.fault) break;
        end
        check_int("t2_pll_reset_rises", rises, 3);
        check_int("t2_retry_steps", retry_seq.size(), 2);
        check_int("t2_retry_first", (retry_seq.size() > 0) ? retry_seq[0] : -1, 1);
        check_int("t2_retry_second", (retry_seq.size() > 1) ? retry_seq[1] : -1, 2);
        repeat (30) cycle(1'b0, 1'b0, "t2_fault_hold");
        check_int("t2_fault_latched", int'({bus.fault, bus.pll_reset, bus.retry_cnt}), 'b11_0010);

        // 5a. restart from FAULT
        cycle(1'b0, 1'b1, "t5_restart");
        check_int("t5_fault_cleared", int'({bus.fault, bus.retry_cnt}), 0);
        hi = int'(bus.pll_reset);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, "t5_pulse");
            if (bus.pll_reset) hi++;
            else break;
        end
        check_int("t5_pulse_len", hi, RP);

        // 5b. restart on the very cycle of a timeout
        for (int i = 0; i < 100; i++) begin
            if (mode == M_WAIT && retries == 1 && wait_left == 1) break;
            cycle(1'b0, 1'b0, "t5b_wait");
        end
        check_int("t5b_reached_timeout", int'(bus.retry_cnt), 1);
        cycle(1'b0, 1'b1, "t5b_restart");
        check_int("t5b_priority", int'({bus.pll_reset, bus.fault, bus.retry_cnt}), 'b10_0000);

        rand_run(600);

        // 6. asynchronous reset in the middle of STABLE
        cycle(1'b1, 1'b1, "t6_restart");
        for (int i = 0; i < 40; i++) begin
            if (mode == M_QUAL && qual_run >= 3) break;
            cycle(1'b1, 1'b0, "t6_qual");
        end
        check_int("t6_in_stable", int'({bus.pll_reset, bus.sys_rst, bus.ready}), 'b010);
        #2;
        reset = 1'b1;
        #1;
        check_vec("t6_async_reset", dut_out(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        model_reset();
        @(negedge clkin);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, "t6_reseq");
            if (bus.ready) break;
        end
        check_int("t6_ready_after_reset", int'(bus.ready), 1);

        rand_run(600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
